// File: rtl/fsm_pkg.sv
// Shared constants for the traffic-control input path: field geometry,
// field indices within the pad bus and the default debounce depth.
`default_nettype none

package fsm_pkg;
  localparam int FIELD_W          = 2;
  localparam int N_FIELDS         = 4;
  localparam int F_G1             = 0;
  localparam int F_G2             = 1;
  localparam int F_A              = 2;
  localparam int F_P              = 3;
  localparam int DEBOUNCE_DEFAULT = 4;
endpackage

`default_nettype wire

// File: rtl/field_debounce.sv
// Debounces one 2-bit request field: a new value is forwarded only after it
// has been seen on DEBOUNCE_CYCLES consecutive enabled samples.
`default_nettype none

module field_debounce
  import fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [FIELD_W-1:0] din,
  output logic [FIELD_W-1:0] dout,
  output logic               chg
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  // The candidate load is sample 1, so the final sample arrives when cnt
  // already holds DEBOUNCE_CYCLES-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [FIELD_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FIELD_W-1:0] out_q, out_d;
  logic               chg_q, chg_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    chg_d  = 1'b0;
    if (en) begin
      if (din != cand_q) begin
        cand_d = din;
        cnt_d  = '0;
      end else if (cand_q != out_q) begin
        if (cnt_q == CNT_LAST) begin
          out_d = cand_q;
          chg_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      chg_q  <= chg_d;
    end
  end

  assign dout = out_q;
  assign chg  = chg_q;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// Synchronises the raw pad bus into clk and debounces each 2-bit request
// field independently before it reaches the traffic-control FSM.
`default_nettype none

module input_conditioner
  import fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [FIELD_W*N_FIELDS-1:0] ui_in,
  output logic [FIELD_W-1:0]          G1,
  output logic [FIELD_W-1:0]          G2,
  output logic [FIELD_W-1:0]          A,
  output logic [FIELD_W-1:0]          P,
  output logic [N_FIELDS-1:0]         chg
);

  logic [FIELD_W*N_FIELDS-1:0] s1_q, s1_d;
  logic [FIELD_W*N_FIELDS-1:0] s2_q, s2_d;
  logic [FIELD_W-1:0]          field_out [N_FIELDS];

  // The synchroniser keeps running while en is low so that re-enabling
  // never consumes stale pad values.
  always_comb begin
    s1_d = ui_in;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  for (genvar f = 0; f < N_FIELDS; f++) begin : g_field
    field_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_field_debounce (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .din  (s2_q[FIELD_W*f +: FIELD_W]),
      .dout (field_out[f]),
      .chg  (chg[f])
    );
  end

  assign G1 = field_out[F_G1];
  assign G2 = field_out[F_G2];
  assign A  = field_out[F_A];
  assign P  = field_out[F_P];

endmodule

`default_nettype wire

// File: doc/input_conditioner.md
# input_conditioner

Upstream stage of the traffic-control FSM: takes the raw 8-bit pad input bus, synchronises it into the `clk` domain and debounces it as four independent 2-bit request fields (G1, G2, A, P). Only values held stable for `DEBOUNCE_CYCLES` consecutive synchronised samples are forwarded. It drives the FSM's G1/G2/A/P inputs directly and flags each accepted change with a one-cycle strobe.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive equal synchronised samples needed to accept a new field value; legal range 2..255.
- `clk`  input  1  single clock for all state.
- `reset`  input  1  synchronous, active-high reset.
- `en`  input  1  advance enable; low freezes debounce state.
- `ui_in`  input  8  raw asynchronous pad bits; field f = `ui_in[2f+1:2f]`, with f0=G1, f1=G2, f2=A, f3=P.
- `G1`, `G2`, `A`, `P`  output  2 each  debounced field values to the FSM.
- `chg`  output  4  one-cycle strobe; bit f high in the cycle after field f's output updates.

## Operation
- Synchroniser: two flop stages, `s1 <= ui_in` and `s2 <= s1`, on every edge regardless of `en`.
- Each field has its own state: `cand` (2b), `cnt` (counter of `$clog2(DEBOUNCE_CYCLES)` bits, minimum 1), `out` (2b).
- Per field, on each edge with `en`=1, evaluated in priority order:
  - If `s2_f != cand`: `cand <= s2_f`, `cnt <= 0`. This load counts as sample 1.
  - Else if `cand != out` and `cnt == DEBOUNCE_CYCLES-2`: `out <= cand`, `chg[f] <= 1`.
  - Else if `cand != out`: `cnt <= cnt+1`.
  - Else (`cand == out`): hold; `cnt` unchanged.
- `chg[f]` is 0 in every cycle not covered by the update rule above.
- When `en`=0: `cand`, `cnt` and `out` hold, `chg` is 0, and the synchroniser keeps running.
- Fields are fully independent. Several fields may update and strobe in the same cycle.
- Glitch rule: a field change must stay stable at `s2` for `DEBOUNCE_CYCLES` consecutive samples to be accepted. A shorter excursion is discarded.
- Bounce back to the current `out` value before acceptance: `cand` reloads to the `out` value; no update, no strobe.
- Change to a third value mid-count: `cand` reloads and the count restarts from sample 1.

## Timing
- Reset values: `s1`, `s2`, and every `cand`, `cnt` and `out` are 0; `G1`/`G2`/`A`/`P` are 2'b00; `chg` is 4'b0000.
- `reset` has priority over `en`. Asserting it mid-count abandons the pending candidate and returns all outputs to 0 on the next edge.
- Latency: `ui_in` value first sampled at edge 0 → `s2` at edge 1 → `cand` loaded at edge 2 → `out` updated at edge `DEBOUNCE_CYCLES+1`. `chg[f]` is high for exactly the cycle after that edge. With the default of 4, this is 5 edges.
- Outputs are registered. There is no combinational path from `ui_in` to any output.
- Holding `en` low during a count stretches the latency by the number of disabled cycles. The count is neither lost nor reset.

## Structure
- Shared package `fsm_pkg`:
  - `FIELD_W = 2` and `N_FIELDS = 4`.
  - Field index constants `F_G1`, `F_G2`, `F_A`, `F_P`.
  - `DEBOUNCE_DEFAULT = 4`.
- Sub-module `field_debounce`: one 2-bit field's `cand`/`cnt`/`out`/strobe logic, parameterised by `DEBOUNCE_CYCLES`.
- The top level holds the synchroniser and four `field_debounce` instances, with outputs mapped by the package indices.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 unless noted.
1. Reset: drive `reset`=1 with `ui_in`=8'hFF for 3 cycles → all outputs 0 and `chg`=0. Release and hold 8'hFF → after edge 5 all fields read 2'b11; `chg`=4'hF for one cycle only.
2. Glitch rejection: from all-zero, pulse `ui_in[1:0]`=2'b10 for 3 cycles → `G1` stays 00 and `chg` stays 0. Pulse it for 4 cycles → `G1`=10 after edge 5 and `chg[0]` pulses once.
3. Mid-count redirect: `A` field 00→01 for 2 cycles, then →11 held → `A` goes straight to 11, 4 samples after the 11 first reaches `s2`; 01 never appears.
4. Independence: `G2`=01 at edge 0 and `P`=10 at edge 2 → `G2` updates after edge 5 and `P` after edge 7; each `chg` bit pulses alone.
5. Enable freeze: start a `G1` change, then hold `en`=0 for 3 cycles after the candidate load → update is delayed exactly 3 cycles; `chg` stays 0 while `en` is low.
6. Reset mid-count and minimum setting: assert `reset` 2 cycles into a count → outputs stay 0 after release until a fresh 4-sample window completes. With `DEBOUNCE_CYCLES`=2, a 2-cycle pulse is accepted and a 1-cycle pulse is rejected.
